fft_out_sink: RTL and testbench



---
 rtl/fft_pkg.sv | 23 ++
 rtl/fft_pingpong_ram.sv | 38 +++
 rtl/fft_out_sink.sv | 165 ++++++++++++++++
 tb/tb_fft_out_sink.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared constants, types and helpers for the FFT output sink and its ping-pong store.
package fft_pkg;

    localparam int unsigned DATA_W    = 16;
    localparam int unsigned LOG2N     = 4;
    localparam int unsigned MAX_LOG2N = 8;

    typedef struct packed {
        logic signed [DATA_W-1:0] re;
        logic signed [DATA_W-1:0] im;
    } cplx_t;

    typedef enum logic [0:0] {StIdle, StDrain} rd_state_e;

    // Reverses the low nbits of idx; callers zero-extend idx to MAX_LOG2N bits.
    function automatic logic [MAX_LOG2N-1:0] bitrev(input logic [MAX_LOG2N-1:0] idx,
                                                    input int unsigned nbits);
        logic [MAX_LOG2N-1:0] r;
        r = {<<{idx}};
        return r >> (MAX_LOG2N - nbits);
    endfunction

endpackage

// File: rtl/fft_pingpong_ram.sv
// Two-bank frame store: one write port, one registered read port, addressed by {bank, idx}.
module fft_pingpong_ram #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned LOG2N  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [LOG2N:0]    wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [LOG2N:0]    rd_addr,
    output logic [WORD_W-1:0] rd_data
);

    localparam int unsigned DEPTH = 2 ** (LOG2N + 1);

    logic [WORD_W-1:0] mem [DEPTH];
    logic [WORD_W-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // The read register doubles as the sink's output data register, so it holds unless rd_en.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/fft_out_sink.sv
// Collects bit-reversed FFT frames into ping-pong banks and replays them in natural order.
// Optional sticky push-during-stall error flag enabled by defining SINK_ERR_EN.
module fft_out_sink #(
    parameter int unsigned DATA_W      = fft_pkg::DATA_W,
    parameter int unsigned LOG2N       = fft_pkg::LOG2N,
    parameter bit          BIT_REVERSE = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_push,
    input  logic [DATA_W-1:0] in_real,
    input  logic [DATA_W-1:0] in_imag,
    output logic              in_stall_F,
    output logic              out_valid_F,
    output logic [DATA_W-1:0] out_real_F,
    output logic [DATA_W-1:0] out_imag_F,
    output logic              out_last_F,
    input  logic              out_ready,
    output logic              frame_err_F
);

    import fft_pkg::*;

    localparam int unsigned N = 2 ** LOG2N;
    typedef logic [LOG2N-1:0] idx_t;

    rd_state_e state_q, state_d;
    logic [1:0] full_q, full_d;
    idx_t       wr_idx_q, rd_idx_q, rd_idx_d;
    logic       wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
    logic       stall_q, valid_q, valid_d, last_q, last_d;

    logic              wr_fire, wr_done, hs, rd_last, other_full, free, rd_en;
    idx_t              wr_slot;
    logic [LOG2N:0]    wr_addr, rd_addr;
    logic [2*DATA_W-1:0] rd_word;

    assign wr_fire    = in_push & ~stall_q;
    assign wr_done    = wr_fire & (&wr_idx_q);
    assign wr_bank_d  = wr_done ? ~wr_bank_q : wr_bank_q;
    assign wr_slot    = BIT_REVERSE ? idx_t'(bitrev(MAX_LOG2N'(wr_idx_q), LOG2N)) : wr_idx_q;
    assign wr_addr    = {wr_bank_q, wr_slot};
    assign hs         = valid_q & out_ready;
    assign rd_last    = &rd_idx_q;
    assign other_full = full_q[~rd_bank_q];
    assign rd_addr    = {rd_bank_d, rd_idx_d};

    fft_pingpong_ram #(
        .WORD_W (2 * DATA_W),
        .LOG2N  (LOG2N)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_fire),
        .wr_addr (wr_addr),
        .wr_data ({in_real, in_imag}),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_idx_q  <= '0;
            wr_bank_q <= 1'b0;
        end else if (wr_fire) begin
            wr_idx_q  <= wr_idx_q + 1'b1;
            wr_bank_q <= wr_bank_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            full_q    <= '0;
            rd_idx_q  <= '0;
            rd_bank_q <= 1'b0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            stall_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            full_q    <= full_d;
            rd_idx_q  <= rd_idx_d;
            rd_bank_q <= rd_bank_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            stall_q   <= full_d[wr_bank_d];
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (full_q[rd_bank_q]) state_d = StDrain;
            StDrain: if (hs && rd_last && !other_full) state_d = StIdle;
        endcase
    end

    always_comb begin
        rd_en     = 1'b0;
        free      = 1'b0;
        rd_idx_d  = rd_idx_q;
        rd_bank_d = rd_bank_q;
        valid_d   = valid_q;
        last_d    = last_q;
        unique case (state_q)
            StIdle: begin
                valid_d = 1'b0;
                last_d  = 1'b0;
                if (full_q[rd_bank_q]) begin
                    rd_en    = 1'b1;
                    rd_idx_d = '0;
                    valid_d  = 1'b1;
                end
            end
            StDrain: begin
                if (hs) begin
                    if (!rd_last) begin
                        rd_en    = 1'b1;
                        rd_idx_d = rd_idx_q + 1'b1;
                        last_d   = (rd_idx_q == idx_t'(N - 2));
                    end else begin
                        // Frame done: release the bank and chain straight into the next one.
                        free      = 1'b1;
                        rd_bank_d = ~rd_bank_q;
                        rd_idx_d  = '0;
                        last_d    = 1'b0;
                        rd_en     = other_full;
                        valid_d   = other_full;
                    end
                end
            end
        endcase
    end

    always_comb begin
        full_d = full_q;
        if (free) full_d[rd_bank_q] = 1'b0;
        if (wr_done) full_d[wr_bank_q] = 1'b1;
    end

`ifdef SINK_ERR_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (in_push && stall_q) begin
            err_q <= 1'b1;
        end
    end

    assign frame_err_F = err_q;
`else
    assign frame_err_F = 1'b0;
`endif

    assign in_stall_F  = stall_q;
    assign out_valid_F = valid_q;
    assign out_last_F  = last_q;
    assign out_real_F  = rd_word[2*DATA_W-1:DATA_W];
    assign out_imag_F  = rd_word[DATA_W-1:0];

endmodule

// File: tb/tb_fft_out_sink.sv
// Bench for fft_out_sink: frame-queue reference model compared every cycle, plus literal checks.
module tb_fft_out_sink;

    import fft_pkg::*;

    localparam int N = 16;
`ifdef SINK_ERR_EN
    localparam bit EXP_ERR = 1'b1;
`else
    localparam bit EXP_ERR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_push = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] in_real = '0;
    logic [15:0] in_imag = '0;

    logic        stall_a, valid_a, last_a, err_a;
    logic [15:0] real_a, imag_a;
    logic        stall_b, valid_b, last_b, err_b;
    logic [15:0] real_b, imag_b;

    always #5 clk = ~clk;

    fft_out_sink #(.DATA_W(16), .LOG2N(4), .BIT_REVERSE(1'b1)) u_br (
        .clk(clk), .reset(reset), .in_push(in_push), .in_real(in_real), .in_imag(in_imag),
        .in_stall_F(stall_a), .out_valid_F(valid_a), .out_real_F(real_a), .out_imag_F(imag_a),
        .out_last_F(last_a), .out_ready(out_ready), .frame_err_F(err_a)
    );

    fft_out_sink #(.DATA_W(16), .LOG2N(4), .BIT_REVERSE(1'b0)) u_nr (
        .clk(clk), .reset(reset), .in_push(in_push), .in_real(in_real), .in_imag(in_imag),
        .in_stall_F(stall_b), .out_valid_F(valid_b), .out_real_F(real_b), .out_imag_F(imag_b),
        .out_last_F(last_b), .out_ready(out_ready), .frame_err_F(err_b)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int mbitrev(input int k);
        int r = 0;
        for (int b = 0; b < 4; b++) if ((k >> b) & 1) r |= 1 << (3 - b);
        return r;
    endfunction

    // Reference model: completed frames wait in queues in output order; two held frames stall.
    cplx_t partial[$];
    cplx_t fq_a[$];
    cplx_t fq_b[$];
    bit    m_valid = 1'b0;
    bit    m_stall = 1'b0;
    bit    m_err = 1'b0;
    int    m_pos = 0;

    always @(posedge clk) begin
        int held_pre;
        bit accept;
        if (reset) begin
            partial.delete(); fq_a.delete(); fq_b.delete();
            m_valid = 1'b0; m_stall = 1'b0; m_err = 1'b0; m_pos = 0;
        end else begin
            held_pre = fq_a.size() / N;
            accept = in_push && !m_stall;
            if (in_push && m_stall && EXP_ERR) m_err = 1'b1;
            if (m_valid && out_ready) begin
                if (m_pos < N - 1) begin
                    m_pos++;
                end else begin
                    repeat (N) begin
                        void'(fq_a.pop_front());
                        void'(fq_b.pop_front());
                    end
                    m_pos = 0;
                    m_valid = (held_pre >= 2);
                end
            end else if (!m_valid && held_pre >= 1) begin
                m_valid = 1'b1;
                m_pos = 0;
            end
            if (accept) begin
                partial.push_back('{re: in_real, im: in_imag});
                if (partial.size() == N) begin
                    for (int k = 0; k < N; k++) begin
                        fq_a.push_back(partial[mbitrev(k)]);
                        fq_b.push_back(partial[k]);
                    end
                    partial.delete();
                end
            end
            m_stall = (fq_a.size() / N == 2);
        end
    end

    logic [15:0] log_a[$];
    logic [15:0] log_b[$];
    int          hs_cyc[$];
    int          first_valid_cyc = -1;
    int          stall_fall_cyc = -1;
    bit          stall_seen = 1'b0;
    bit          prev_valid = 1'b0;
    bit          prev_stall = 1'b0;

    always @(negedge clk) begin
        cplx_t ea, eb;
        chk("stall_a", int'(stall_a), int'(m_stall));
        chk("stall_b", int'(stall_b), int'(m_stall));
        chk("valid_a", int'(valid_a), int'(m_valid));
        chk("valid_b", int'(valid_b), int'(m_valid));
        chk("last_a", int'(last_a), int'(m_valid && m_pos == N - 1));
        chk("last_b", int'(last_b), int'(m_valid && m_pos == N - 1));
        chk("err_a", int'(err_a), int'(m_err));
        chk("err_b", int'(err_b), int'(m_err));
        if (m_valid) begin
            ea = fq_a[m_pos];
            eb = fq_b[m_pos];
            chk("real_a", int'(real_a), int'($unsigned(ea.re)));
            chk("imag_a", int'(imag_a), int'($unsigned(ea.im)));
            chk("real_b", int'(real_b), int'($unsigned(eb.re)));
            chk("imag_b", int'(imag_b), int'($unsigned(eb.im)));
        end
        if (valid_a && out_ready) begin
            log_a.push_back(real_a);
            log_b.push_back(real_b);
            hs_cyc.push_back(cyc);
        end
        if (valid_a && !prev_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (!stall_a && prev_stall) stall_fall_cyc = cyc;
        if (stall_a) stall_seen = 1'b1;
        prev_valid = valid_a;
        prev_stall = stall_a;
    end

    task automatic push(input int re, input int im);
        @(posedge clk); #1;
        in_push = 1'b1;
        in_real = 16'(re);
        in_imag = 16'(im);
    endtask

    task automatic idle_in();
        @(posedge clk); #1;
        in_push = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        in_push = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic clear_logs();
        log_a.delete(); log_b.delete(); hs_cyc.delete();
        first_valid_cyc = -1; stall_fall_cyc = -1; stall_seen = 1'b0;
    endtask

    task automatic wait_hs(input string nm, input int n, input int budget);
        int i = 0;
        while (log_a.size() < n && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk(nm, log_a.size(), n);
    endtask

    initial begin
        int last_push_cyc, mask, cnt;

        // Reset state
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_valid", int'(valid_a), 0);
        chk("rst_stall", int'(stall_a), 0);
        chk("rst_last", int'(last_a), 0);
        chk("rst_real", int'(real_a), 0);
        chk("rst_imag", int'(imag_a), 0);
        chk("rst_err", int'(err_a), 0);
        reset = 1'b0;

        // One frame, index order, ready held high
        clear_logs();
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) push(i, -i);
        last_push_cyc = cyc;
        idle_in();
        wait_hs("t1_count", N, 60);
        chk("t1_latency", first_valid_cyc - last_push_cyc, 2);
        chk("t1_br_0", int'(log_a[0]), 0);
        chk("t1_br_1", int'(log_a[1]), 8);
        chk("t1_br_2", int'(log_a[2]), 4);
        chk("t1_br_3", int'(log_a[3]), 12);
        chk("t1_br_15", int'(log_a[15]), 15);
        chk("t1_nr_5", int'(log_b[5]), 5);
        chk("t1_nr_15", int'(log_b[15]), 15);
        chk("t1_no_stall", int'(stall_seen), 0);

        // Two frames back-to-back with the consumer blocked
        clear_logs();
        out_ready = 1'b0;
        for (int i = 0; i < 2 * N; i++) begin
            push(200 + i, i);
            if (i == 2 * N - 1) chk("t3_stall_before", int'(stall_a), 0);
        end
        idle_in();
        chk("t3_stall_set", int'(stall_a), 1);
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
        wait_hs("t3_count", 2 * N, 80);
        chk("t3_no_bubble", hs_cyc[2*N-1] - hs_cyc[0], 2 * N - 1);
        chk("t3_stall_drop", stall_fall_cyc, hs_cyc[N-1] + 1);
        chk("t3_f0_e0", int'(log_a[0]), 200);
        chk("t3_f1_e0", int'(log_a[N]), 216);
        chk("t3_f1_e1", int'(log_a[N+1]), 224);

        // Random back-pressure during fill and drain
        clear_logs();
        for (int i = 0; i < N; i++) begin
            push(300 + i, 7 * i);
            out_ready = 1'($urandom_range(0, 1));
        end
        idle_in();
        repeat (40) begin
            @(posedge clk); #1;
            out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
        wait_hs("t4_count", N, 60);
        mask = 0;
        foreach (log_a[k]) mask |= 1 << (int'(log_a[k]) - 300);
        chk("t4_each_once", mask, 32'hFFFF);

        // Reset mid-frame discards the partial frame
        clear_logs();
        for (int i = 0; i < 7; i++) push(50 + i, i);
        do_reset();
        for (int i = 0; i < N; i++) push(100 + i, -i);
        idle_in();
        wait_hs("t5_count", N, 60);
        repeat (30) @(negedge clk);
        chk("t5_only_new", log_a.size(), N);
        chk("t5_e0", int'(log_a[0]), 100);
        chk("t5_e1", int'(log_a[1]), 108);
        chk("t5_e15", int'(log_a[15]), 115);

        // Push while stalled is dropped and flagged when the error feature is built in
        clear_logs();
        out_ready = 1'b0;
        for (int i = 0; i < 2 * N; i++) push(400 + i, i);
        push(999, 999);
        idle_in();
        chk("t6_err_set", int'(err_a), int'(EXP_ERR));
        #1 out_ready = 1'b1;
        wait_hs("t6_count", 2 * N, 80);
        cnt = 0;
        foreach (log_a[k]) if (log_a[k] == 16'd999) cnt++;
        chk("t6_dropped", cnt, 0);
        chk("t6_f1_e15", int'(log_a[2*N-1]), 431);
        repeat (5) @(negedge clk);
        chk("t6_err_sticky", int'(err_a), int'(EXP_ERR));
        do_reset();
        chk("t6_err_cleared", int'(err_a), 0);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
